geri_yaz_yazmac_obegi: RTL

//  Writeback stage plus the integer register file, directly downstream of the execute stage.
//  - Selects the final rd value from the execute stage's registered outputs and commits it to x1..x31.
//  - Serves the two decode/register-read ports, with a same-cycle write bypass.
//  - Drives the writeback forwarding value and a 64-bit retired-instruction counter for CSR use.

---
 rtl/geri_yaz_yazmac_obegi.sv | 92 +++++++++
 1 files changed

// File: rtl/geri_yaz_yazmac_obegi.sv
// Writeback stage and integer register file: selects the rd value, commits it to x1..x31,
// serves two bypassed read ports and keeps the retired-instruction counter.
module geri_yaz_yazmac_obegi #(
  parameter int unsigned ADRES_BIT = 5,
  parameter int unsigned SAYAC_BIT = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 yurut_gecerli_i,
  input  logic [2:0]           yurut_mikroislem_i,
  input  logic [ADRES_BIT-1:0] yurut_rd_adres_i,
  input  logic [31:0]          yurut_rd_deger_i,
  input  logic [31:0]          yurut_ps_artmis_i,
  input  logic [31:0]          yurut_bib_deger_i,
  input  logic [31:0]          yurut_carpma_deger_i,
  input  logic                 ddb_durdur_i,
  input  logic [ADRES_BIT-1:0] cyo_rs1_adres_i,
  input  logic [ADRES_BIT-1:0] cyo_rs2_adres_i,
  output logic [31:0]          cyo_rs1_deger_o,
  output logic [31:0]          cyo_rs2_deger_o,
  output logic [31:0]          cyo_yonlendir_deger_o,
  output logic                 cyo_yonlendir_gecerli_o,
  output logic [SAYAC_BIT-1:0] csr_instret_o
);

  localparam int unsigned VERI_BIT   = 32;
  localparam int unsigned YAZMAC_SAY = 2 ** ADRES_BIT;

  logic [VERI_BIT-1:0]  yazmac_q [YAZMAC_SAY];
  logic [SAYAC_BIT-1:0] instret_q;
  logic [VERI_BIT-1:0]  yaz_deger;
  logic                 commit;
  logic                 yaz;

  // Final rd value from the execute stage's registered results.
  always_comb begin
    yaz_deger = yurut_rd_deger_i;
    unique case (yurut_mikroislem_i[2:1])
      2'b00:   yaz_deger = yurut_rd_deger_i;
      2'b01:   yaz_deger = yurut_ps_artmis_i;
      2'b10:   yaz_deger = yurut_bib_deger_i;
      default: yaz_deger = yurut_carpma_deger_i;
    endcase
  end

  assign commit = yurut_gecerli_i & ~ddb_durdur_i & ~rst_i;
  assign yaz    = commit & yurut_mikroislem_i[0] & (yurut_rd_adres_i != '0);

  assign cyo_yonlendir_deger_o   = yaz_deger;
  assign cyo_yonlendir_gecerli_o = yaz;
  assign csr_instret_o           = instret_q;

  // Register array; reset clears every entry and wins over a same-cycle write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(YAZMAC_SAY); i++) begin
        yazmac_q[i] <= '0;
      end
    end else if (yaz) begin
      yazmac_q[yurut_rd_adres_i] <= yaz_deger;
    end
  end

  // Counts every committed instruction, wrapping silently.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      instret_q <= '0;
    end else if (commit) begin
      instret_q <= instret_q + SAYAC_BIT'(1);
    end
  end

  // Read port 1: x0 reads zero, otherwise same-cycle bypass before the array.
  always_comb begin
    cyo_rs1_deger_o = yazmac_q[cyo_rs1_adres_i];
    if (cyo_rs1_adres_i == '0) begin
      cyo_rs1_deger_o = '0;
    end else if (yaz && (cyo_rs1_adres_i == yurut_rd_adres_i)) begin
      cyo_rs1_deger_o = yaz_deger;
    end
  end

  always_comb begin
    cyo_rs2_deger_o = yazmac_q[cyo_rs2_adres_i];
    if (cyo_rs2_adres_i == '0) begin
      cyo_rs2_deger_o = '0;
    end else if (yaz && (cyo_rs2_adres_i == yurut_rd_adres_i)) begin
      cyo_rs2_deger_o = yaz_deger;
    end
  end

endmodule
